dense_layer_mac: RTL and testbench
==================================

# dense_layer_mac

Sequential fully-connected layer stage: computes y = W·x + b over a packed Q-format input vector, one multiply-accumulate per cycle, reading weights from an external synchronous ROM. It sits directly upstream of `vector_sigmoid`. Its packed `data_out`, `busy` and `done` match that block's `data_in`, `start` and `done` conventions, so `done` can drive the activation stage's `start` directly. All data is signed two's-complement fixed point with Q_FRAC fractional bits.

## Interface
- INPUT_COUNT, 8, elements in x (columns of W)
- OUTPUT_COUNT, 8, elements in y (rows of W)
- DATA_WIDTH, 16, width of every x, w, b and y word
- Q_FRAC, 8, fractional bits of every word
- ACC_WIDTH, 40, signed accumulator width
- ADDR_W, $clog2(INPUT_COUNT*OUTPUT_COUNT), weight ROM address width
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a pass; sampled only in IDLE
- data_in  in  DATA_WIDTH*INPUT_COUNT  packed x; element i at [i*DATA_WIDTH +: DATA_WIDTH]
- bias_in  in  DATA_WIDTH*OUTPUT_COUNT  packed b, same packing
- weight_addr  out  ADDR_W  registered ROM address; W[r][c] lives at r*INPUT_COUNT+c
- weight_data  in  DATA_WIDTH  ROM word addressed by weight_addr in the previous cycle
- data_out  out  DATA_WIDTH*OUTPUT_COUNT  packed y, registered
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse; data_out complete

## Operation
- FSM states: IDLE, FILL, MAC, WRITE, DONE.
- **IDLE**
  - On start: latch data_in and bias_in into internal registers, set row=0 and col=0, weight_addr=0.
  - Init acc = sign_extend(b[0]) <<< Q_FRAC, then go to FILL.
- **FILL (1 cycle)**
  - ROM is sampling weight_addr = row*INPUT_COUNT. No accumulate.
  - weight_addr increments; go to MAC.
- **MAC (INPUT_COUNT cycles)**
  - In cycle k, weight_data = W[row][k]; acc += x[k] * weight_data.
  - Product is full signed 2*DATA_WIDTH, sign-extended to ACC_WIDTH.
  - weight_addr increments every MAC cycle, wrapping modulo 2^ADDR_W. Its value after the last row is don't-care.
  - After k = INPUT_COUNT-1, go to WRITE.
- **WRITE (1 cycle)**
  - y[row] = sat(acc >>> Q_FRAC), using arithmetic shift (floor, no rounding).
  - sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Store into data_out slice row.
  - If row = OUTPUT_COUNT-1, go to DONE. Otherwise row++, acc = sign_extend(b[row+1]) <<< Q_FRAC, go to FILL.
- **DONE (1 cycle)**: done=1, then go to IDLE.
- Latched x/b are used throughout the pass; changes on data_in/bias_in during busy have no effect.
- start outside IDLE (including in DONE) is ignored; no queuing.
- data_out slices update in place per row. Only the full vector at done is valid; it holds until the next pass overwrites it.

## Timing
- Reset values: data_out=0, busy=0, done=0, weight_addr=0, state IDLE, acc=0.
- Reset mid-pass aborts immediately, returning to IDLE with all outputs at their reset values. No done is issued for the aborted pass.
- Per row: INPUT_COUNT+2 cycles (FILL + MAC + WRITE).
- Counting the start-sampling edge as cycle 0:
  - busy is high in cycles 1 .. OUTPUT_COUNT*(INPUT_COUNT+2).
  - done is high in cycle OUTPUT_COUNT*(INPUT_COUNT+2)+1.
  - For defaults: busy in cycles 1..80, done in cycle 81.
- busy and done are never high together.
- Minimum start-to-start period: OUTPUT_COUNT*(INPUT_COUNT+2)+2 cycles (82 for defaults), since start is first accepted in the IDLE cycle after DONE.
- Weight ROM contract: exactly one cycle of read latency, with no enable.

## Test plan
- **Identity:** W = 256·I (1.0 on the diagonal), b = 0, x[i] = 64i−256 → data_out[i] = 64i−256. busy high for exactly 80 cycles; single done pulse at cycle 81.
- **Bias only:** W = 0, b[i] = 100i−300, any x → data_out[i] = 100i−300.
- **Floor behaviour:** all W = 128 (0.5), b = 0, x = {1,0,…,0} → every y = 0. x = {−1,0,…,0} → every y = −1.
- **Saturation:**
  - All W = 32767, all x = 32767, b = 0 → every y = 32767.
  - All x = −32768 → every y = −32768.
- **Control robustness:**
  - start pulsed at cycle 10 of a pass → ignored; result and done timing unchanged.
  - rst asserted at cycle 20, then a fresh start → all outputs 0 during reset, then the identity result with exactly one done.
- **Back-to-back:** start held high continuously with identity W → done pulses every 82 cycles, with data_out correct after each.

Source files
------------

// File: rtl/dense_layer_mac.sv
// dense_layer_mac: sequential fully-connected layer, y = W*x + b, one MAC per cycle.
//
// Weights come from an external synchronous ROM with one cycle of read latency.
// All words are signed two's-complement fixed point with Q_FRAC fractional bits.
//
// Ports:
//   clk          single clock, posedge
//   rst          synchronous active-high reset
//   start        begin a pass (sampled only when idle)
//   data_in      packed x, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   bias_in      packed b, same packing
//   weight_addr  registered ROM address, W[r][c] at r*INPUT_COUNT+c
//   weight_data  ROM word for the address presented in the previous cycle
//   data_out     packed y, registered, valid in full when done pulses
//   busy         pass in progress
//   done         one-cycle completion pulse
module dense_layer_mac #(
  parameter int unsigned INPUT_COUNT  = 8,
  parameter int unsigned OUTPUT_COUNT = 8,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned Q_FRAC       = 8,
  parameter int unsigned ACC_WIDTH    = 40,
  parameter int unsigned ADDR_W       = $clog2(INPUT_COUNT * OUTPUT_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [DATA_WIDTH*INPUT_COUNT-1:0]    data_in,
  input  logic [DATA_WIDTH*OUTPUT_COUNT-1:0]   bias_in,
  output logic [ADDR_W-1:0]                    weight_addr,
  input  logic [DATA_WIDTH-1:0]                weight_data,
  output logic [DATA_WIDTH*OUTPUT_COUNT-1:0]   data_out,
  output logic                                 busy,
  output logic                                 done
);

  localparam int unsigned RowW = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1;
  localparam int unsigned ColW = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;

  // Saturation bounds expressed at accumulator width for a signed compare.
  localparam logic signed [ACC_WIDTH-1:0] SatMax =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SatMin =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StFill, StMac, StWrite, StDone} state_e;

  state_e                               state_q, state_d;
  logic [DATA_WIDTH*INPUT_COUNT-1:0]    x_q, x_d;
  logic [DATA_WIDTH*OUTPUT_COUNT-1:0]   b_q, b_d;
  logic signed [ACC_WIDTH-1:0]          acc_q, acc_d;
  logic [RowW-1:0]                      row_q, row_d;
  logic [ColW-1:0]                      col_q, col_d;
  logic [ADDR_W-1:0]                    addr_q, addr_d;
  logic [DATA_WIDTH*OUTPUT_COUNT-1:0]   out_q, out_d;

  logic signed [DATA_WIDTH-1:0]         x_sel;
  logic signed [DATA_WIDTH-1:0]         w_sel;
  logic signed [2*DATA_WIDTH-1:0]       prod;
  logic signed [ACC_WIDTH-1:0]          prod_ext;
  logic signed [ACC_WIDTH-1:0]          acc_shift;
  logic [DATA_WIDTH-1:0]                sat_val;

  // Bias aligned to the accumulator's binary point.
  function automatic logic signed [ACC_WIDTH-1:0] bias_to_acc(input logic [DATA_WIDTH-1:0] b);
    logic signed [ACC_WIDTH-1:0] ext;
    ext = $signed({{(ACC_WIDTH - DATA_WIDTH){b[DATA_WIDTH-1]}}, b});
    return ext <<< Q_FRAC;
  endfunction

  always_comb begin
    x_sel    = $signed(x_q[int'(col_q)*DATA_WIDTH +: DATA_WIDTH]);
    w_sel    = $signed(weight_data);
    prod     = x_sel * w_sel;
    prod_ext = $signed({{(ACC_WIDTH - 2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod});
    // Arithmetic shift floors toward minus infinity.
    acc_shift = acc_q >>> Q_FRAC;
    if (acc_shift > SatMax) begin
      sat_val = SatMax[DATA_WIDTH-1:0];
    end else if (acc_shift < SatMin) begin
      sat_val = SatMin[DATA_WIDTH-1:0];
    end else begin
      sat_val = acc_shift[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    b_d     = b_q;
    acc_d   = acc_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    out_d   = out_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          x_d     = data_in;
          b_d     = bias_in;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
          acc_d   = bias_to_acc(bias_in[0 +: DATA_WIDTH]);
          state_d = StFill;
        end
      end
      StFill: begin
        // ROM is reading the row base address this cycle.
        addr_d  = addr_q + ADDR_W'(1);
        col_d   = '0;
        state_d = StMac;
      end
      StMac: begin
        acc_d  = acc_q + prod_ext;
        addr_d = addr_q + ADDR_W'(1);
        if (col_q == ColW'(INPUT_COUNT - 1)) begin
          col_d   = '0;
          state_d = StWrite;
        end else begin
          col_d = col_q + ColW'(1);
        end
      end
      StWrite: begin
        out_d[int'(row_q)*DATA_WIDTH +: DATA_WIDTH] = sat_val;
        if (row_q == RowW'(OUTPUT_COUNT - 1)) begin
          state_d = StDone;
        end else begin
          row_d   = row_q + RowW'(1);
          acc_d   = bias_to_acc(b_q[(int'(row_q) + 1)*DATA_WIDTH +: DATA_WIDTH]);
          // MAC ran the address one past the next row base; realign it.
          addr_d  = ADDR_W'((int'(row_q) + 1) * int'(INPUT_COUNT));
          state_d = StFill;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
    end
  end

  assign weight_addr = addr_q;
  assign data_out    = out_q;
  assign busy        = (state_q == StFill) || (state_q == StMac) || (state_q == StWrite);
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_dense_layer_mac.sv
module tb_dense_layer_mac;

  localparam int IC = 8;
  localparam int OC = 8;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int XW = DW * IC;
  localparam int YW = DW * OC;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [XW-1:0] data_in;
  logic [YW-1:0] bias_in;
  logic [AW-1:0] weight_addr;
  logic [DW-1:0] weight_data;
  logic [YW-1:0] data_out;
  logic          busy;
  logic          done;

  logic [DW-1:0] w_mem [IC*OC];

  int total = 0;
  int bad   = 0;

  logic [YW-1:0] exp_q [$];

  // Results of the most recent run_pass.
  int            r_done_cyc;
  int            r_done_cnt;
  int            r_busy_cnt;
  int            r_busy_first;
  int            r_busy_last;
  bit            r_overlap;
  bit            r_rst_zero_ok;
  logic [YW-1:0] r_out;

  always #5 clk = ~clk;

  // Synchronous ROM, one cycle latency.
  always @(posedge clk) weight_data <= w_mem[weight_addr];

  dense_layer_mac dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .bias_in     (bias_in),
    .weight_addr (weight_addr),
    .weight_data (weight_data),
    .data_out    (data_out),
    .busy        (busy),
    .done        (done)
  );

  task automatic load_w(input bit identity, input logic [DW-1:0] v);
    for (int r = 0; r < OC; r++)
      for (int c = 0; c < IC; c++)
        w_mem[r*IC+c] = (!identity || r == c) ? v : '0;
  endtask

  function automatic logic [XW-1:0] identity_x();
    logic [XW-1:0] v;
    for (int i = 0; i < IC; i++) v[i*DW +: DW] = DW'(64*i - 256);
    return v;
  endfunction

  // Start a pass at cycle 0 and observe cycles 1..win (sampled on negedge).
  task automatic run_pass(input logic [XW-1:0] xv, input logic [YW-1:0] bv,
                          input int inject_cyc, input int rst_cyc, input int win);
    r_done_cyc = -1; r_done_cnt = 0; r_busy_cnt = 0; r_busy_first = -1; r_busy_last = -1;
    r_overlap = 0; r_rst_zero_ok = 1; r_out = 'x;
    @(negedge clk);
    data_in = xv; bias_in = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= win; n++) begin
      @(negedge clk);
      if (busy) begin
        r_busy_cnt++;
        if (r_busy_first < 0) r_busy_first = n;
        r_busy_last = n;
      end
      if (done) begin
        r_done_cnt++;
        if (r_done_cyc < 0) begin
          r_done_cyc = n;
          r_out = data_out;
        end
      end
      if (busy && done) r_overlap = 1;
      if (rst_cyc > 0 && (n == rst_cyc || n == rst_cyc + 1))
        if (busy || done || data_out != '0 || weight_addr != '0) r_rst_zero_ok = 0;
      // Latched operands must not follow the inputs mid-pass.
      if (n == 3) begin
        data_in = {4{$urandom}};
        bias_in = {4{$urandom}};
      end
      start = (n == inject_cyc - 1);
      rst   = (rst_cyc > 0 && (n == rst_cyc - 1 || n == rst_cyc));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; data_in = '0; bias_in = '0;
    load_w(1'b0, '0);
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++;
    if (data_out !== '0) begin bad++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
    total++;
    if (weight_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h exp=0", weight_addr); end
    rst = 1'b0;
  endtask

  task automatic test_identity();
    logic [YW-1:0] e;
    load_w(1'b1, 16'd256);
    for (int i = 0; i < OC; i++) e[i*DW +: DW] = DW'(64*i - 256);
    exp_q.push_back(e);
    run_pass(identity_x(), '0, 0, 0, 90);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL identity_sb empty queue"); end
    else begin
      e = exp_q.pop_front();
      if (r_out !== e) begin bad++; $display("FAIL identity_data got=%h exp=%h", r_out, e); end
    end
    total++; if (r_busy_cnt != 80) begin bad++; $display("FAIL identity_busy_cnt got=%0d exp=80", r_busy_cnt); end
    total++; if (r_busy_first != 1) begin bad++; $display("FAIL identity_busy_first got=%0d exp=1", r_busy_first); end
    total++; if (r_busy_last != 80) begin bad++; $display("FAIL identity_busy_last got=%0d exp=80", r_busy_last); end
    total++; if (r_done_cyc != 81) begin bad++; $display("FAIL identity_done_cyc got=%0d exp=81", r_done_cyc); end
    total++; if (r_done_cnt != 1) begin bad++; $display("FAIL identity_done_cnt got=%0d exp=1", r_done_cnt); end
    total++; if (r_overlap) begin bad++; $display("FAIL identity_overlap got=1 exp=0"); end
  endtask

  task automatic test_bias_only();
    logic [YW-1:0] e;
    logic [YW-1:0] bv;
    load_w(1'b0, '0);
    for (int i = 0; i < OC; i++) bv[i*DW +: DW] = DW'(100*i - 300);
    e = bv;
    exp_q.push_back(e);
    run_pass({4{$urandom}}, bv, 0, 0, 90);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL bias_sb empty queue"); end
    else begin
      e = exp_q.pop_front();
      if (r_out !== e) begin bad++; $display("FAIL bias_data got=%h exp=%h", r_out, e); end
    end
    total++; if (r_done_cyc != 81) begin bad++; $display("FAIL bias_done_cyc got=%0d exp=81", r_done_cyc); end
  endtask

  task automatic test_floor();
    logic [YW-1:0] e;
    logic [XW-1:0] xv;
    load_w(1'b0, 16'd128);
    for (int s = 0; s < 2; s++) begin
      xv = '0;
      xv[0 +: DW] = (s == 0) ? 16'd1 : 16'hFFFF;
      e = (s == 0) ? {OC{16'h0000}} : {OC{16'hFFFF}};
      exp_q.push_back(e);
      run_pass(xv, '0, 0, 0, 90);
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL floor_sb empty queue"); end
      else begin
        e = exp_q.pop_front();
        if (r_out !== e) begin bad++; $display("FAIL floor_%0d got=%h exp=%h", s, r_out, e); end
      end
    end
  endtask

  task automatic test_saturation();
    logic [YW-1:0] e;
    load_w(1'b0, 16'h7FFF);
    for (int s = 0; s < 2; s++) begin
      e = (s == 0) ? {OC{16'h7FFF}} : {OC{16'h8000}};
      exp_q.push_back(e);
      run_pass((s == 0) ? {IC{16'h7FFF}} : {IC{16'h8000}}, '0, 0, 0, 90);
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL sat_sb empty queue"); end
      else begin
        e = exp_q.pop_front();
        if (r_out !== e) begin bad++; $display("FAIL sat_%0d got=%h exp=%h", s, r_out, e); end
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [YW-1:0] e;
    load_w(1'b1, 16'd256);
    for (int i = 0; i < OC; i++) e[i*DW +: DW] = DW'(64*i - 256);
    exp_q.push_back(e);
    run_pass(identity_x(), '0, 10, 0, 90);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL restart_sb empty queue"); end
    else begin
      e = exp_q.pop_front();
      if (r_out !== e) begin bad++; $display("FAIL restart_data got=%h exp=%h", r_out, e); end
    end
    total++; if (r_done_cyc != 81) begin bad++; $display("FAIL restart_done_cyc got=%0d exp=81", r_done_cyc); end
    total++; if (r_done_cnt != 1) begin bad++; $display("FAIL restart_done_cnt got=%0d exp=1", r_done_cnt); end
  endtask

  task automatic test_reset_abort();
    logic [YW-1:0] e;
    load_w(1'b1, 16'd256);
    run_pass(identity_x(), '0, 0, 20, 90);
    total++; if (r_done_cnt != 0) begin bad++; $display("FAIL abort_done_cnt got=%0d exp=0", r_done_cnt); end
    total++; if (!r_rst_zero_ok) begin bad++; $display("FAIL abort_outputs got=nonzero exp=zero"); end
    total++; if (r_busy_cnt != 19) begin bad++; $display("FAIL abort_busy_cnt got=%0d exp=19", r_busy_cnt); end
    for (int i = 0; i < OC; i++) e[i*DW +: DW] = DW'(64*i - 256);
    exp_q.push_back(e);
    run_pass(identity_x(), '0, 0, 0, 90);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL abort_sb empty queue"); end
    else begin
      e = exp_q.pop_front();
      if (r_out !== e) begin bad++; $display("FAIL abort_data got=%h exp=%h", r_out, e); end
    end
    total++; if (r_done_cnt != 1) begin bad++; $display("FAIL abort_rerun_done_cnt got=%0d exp=1", r_done_cnt); end
    total++; if (r_done_cyc != 81) begin bad++; $display("FAIL abort_rerun_done_cyc got=%0d exp=81", r_done_cyc); end
  endtask

  task automatic test_back_to_back();
    logic [YW-1:0] e;
    int            k;
    bit            overlap;
    load_w(1'b1, 16'd256);
    for (int i = 0; i < OC; i++) e[i*DW +: DW] = DW'(64*i - 256);
    for (int p = 0; p < 3; p++) exp_q.push_back(e);
    k = 0; overlap = 0;
    @(negedge clk);
    data_in = identity_x(); bias_in = '0; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 250; n++) begin
      @(negedge clk);
      if (busy && done) overlap = 1;
      if (done) begin
        total++;
        if (n != 81 + 82*k) begin bad++; $display("FAIL b2b_done_cyc%0d got=%0d exp=%0d", k, n, 81 + 82*k); end
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_sb empty queue at cycle %0d", n); end
        else begin
          e = exp_q.pop_front();
          if (data_out !== e) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", k, data_out, e); end
        end
        k++;
      end
    end
    start = 1'b0;
    total++; if (k != 3) begin bad++; $display("FAIL b2b_done_cnt got=%0d exp=3", k); end
    total++; if (overlap) begin bad++; $display("FAIL b2b_overlap got=1 exp=0"); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_bias_only();
    test_floor();
    test_saturation();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
